// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_arbiter: IF/LS arbiter and sequencer for a single-port fixed-latency   |
// | memory. Define ARB_ROUND_ROBIN_EN for round-robin ties (else LS priority). |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module mem_arbiter #(
  parameter int WORD_SIZE   = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   if_req_i,
  input  logic [WORD_SIZE-1:0]   if_addr_i,
  output logic                   if_gnt_o,
  output logic                   if_rvalid_o,
  output logic [WORD_SIZE-1:0]   if_rdata_o,
  input  logic                   ls_req_i,
  input  logic                   ls_we_i,
  input  logic [WORD_SIZE/8-1:0] ls_be_i,
  input  logic [WORD_SIZE-1:0]   ls_addr_i,
  input  logic [WORD_SIZE-1:0]   ls_wdata_i,
  output logic                   ls_gnt_o,
  output logic                   ls_rvalid_o,
  output logic [WORD_SIZE-1:0]   ls_rdata_o,
  output logic                   mem_en_o,
  output logic                   mem_we_o,
  output logic [WORD_SIZE/8-1:0] mem_be_o,
  output logic [WORD_SIZE-1:0]   mem_addr_o,
  output logic [WORD_SIZE-1:0]   mem_wdata_o,
  input  logic [WORD_SIZE-1:0]   mem_rdata_i
);

  localparam logic [1:0] c_CNT_LOAD = 2'(MEM_LATENCY - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t     r_state;
  logic [1:0] r_cnt;
  logic       r_owner_ls;
  logic       r_owner_we;

  logic w_resp;
  logic w_can_grant;
  logic w_ls_wins_tie;
  logic w_ls_gnt;
  logic w_if_gnt;

  assign w_resp = (r_state == ST_BUSY) && (r_cnt == 2'd0);
  // Grants are masked while reset is held so no output can rise during reset.
  assign w_can_grant = rst_n && ((r_state == ST_IDLE) || w_resp);

  assign w_ls_gnt = w_can_grant && ls_req_i && (!if_req_i || w_ls_wins_tie);
  assign w_if_gnt = w_can_grant && if_req_i && !w_ls_gnt;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_ls;

  // Last winner starts as IF so the first tie after reset goes to LS.
  assign w_ls_wins_tie = !r_last_ls;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_ls <= 1'b0;
    end else if (w_ls_gnt || w_if_gnt) begin
      r_last_ls <= w_ls_gnt;
    end
  end
`else
  assign w_ls_wins_tie = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 2'd0;
      r_owner_ls <= 1'b0;
      r_owner_we <= 1'b0;
    end else begin
      if (w_if_gnt || w_ls_gnt) begin
        r_state    <= ST_BUSY;
        r_cnt      <= c_CNT_LOAD;
        r_owner_ls <= w_ls_gnt;
        r_owner_we <= w_ls_gnt && ls_we_i;
      end else if (w_resp) begin
        r_state    <= ST_IDLE;
        r_owner_ls <= 1'b0;
        r_owner_we <= 1'b0;
      end else if (r_state == ST_BUSY) begin
        r_cnt <= r_cnt - 2'd1;
      end
    end
  end

  always_comb begin
    if_gnt_o    = w_if_gnt;
    ls_gnt_o    = w_ls_gnt;
    mem_en_o    = w_if_gnt || w_ls_gnt;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (w_ls_gnt) begin
      mem_we_o    = ls_we_i;
      mem_be_o    = ls_be_i;
      mem_addr_o  = ls_addr_i;
      mem_wdata_o = ls_wdata_i;
    end else if (w_if_gnt) begin
      mem_be_o   = '1;
      mem_addr_o = if_addr_i;
    end

    if_rvalid_o = w_resp && !r_owner_ls;
    ls_rvalid_o = w_resp && r_owner_ls;
    if_rdata_o  = '0;
    ls_rdata_o  = '0;
    if (w_resp && !r_owner_ls) begin
      if_rdata_o = mem_rdata_i;
    end
    // A completed store reports zero data.
    if (w_resp && r_owner_ls && !r_owner_we) begin
      ls_rdata_o = mem_rdata_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// tb_mem_arbiter: directed literal checks plus randomized traffic compared every
// cycle against a timestamp-based transaction model (MEM_LATENCY = 2).
module tb_mem_arbiter;
  localparam int WS  = 32;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req_i;
  logic [WS-1:0] if_addr_i;
  logic          if_gnt_o;
  logic          if_rvalid_o;
  logic [WS-1:0] if_rdata_o;
  logic          ls_req_i;
  logic          ls_we_i;
  logic [3:0]    ls_be_i;
  logic [WS-1:0] ls_addr_i;
  logic [WS-1:0] ls_wdata_i;
  logic          ls_gnt_o;
  logic          ls_rvalid_o;
  logic [WS-1:0] ls_rdata_o;
  logic          mem_en_o;
  logic          mem_we_o;
  logic [3:0]    mem_be_o;
  logic [WS-1:0] mem_addr_o;
  logic [WS-1:0] mem_wdata_o;
  logic [WS-1:0] mem_rdata_i;

  mem_arbiter #(.WORD_SIZE(WS), .MEM_LATENCY(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_be_i(ls_be_i),
    .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_o),
    .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Model: at most one outstanding transaction, answered at cycle grant+LAT.
  bit m_busy     = 1'b0;
  bit m_owner_ls = 1'b0;
  bit m_owner_we = 1'b0;
  bit m_last_ls  = 1'b0;
  bit m_if_gnt   = 1'b0;
  bit m_ls_gnt   = 1'b0;
  int m_cyc      = 0;
  int m_due      = 0;

  task automatic chk(input string name, input logic [WS-1:0] act, input logic [WS-1:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic lit(input string name, input logic [WS-1:0] act, input logic [WS-1:0] exp);
    n_vec++;
    chk(name, act, exp);
  endtask

  always @(negedge clk) begin : p_compare
    bit resp, can, tie_ls, e_if, e_ls;
    logic [WS-1:0] e_if_rdata, e_ls_rdata, e_addr, e_wdata;
    logic [3:0] e_be;
    resp = rst_n && m_busy && (m_cyc == m_due);
    can  = rst_n && (!m_busy || resp);
`ifdef ARB_ROUND_ROBIN_EN
    tie_ls = !m_last_ls;
`else
    tie_ls = 1'b1;
`endif
    e_ls = can && ls_req_i && (!if_req_i || tie_ls);
    e_if = can && if_req_i && !e_ls;
    e_addr  = e_ls ? ls_addr_i : (e_if ? if_addr_i : '0);
    e_wdata = e_ls ? ls_wdata_i : '0;
    e_be    = e_ls ? ls_be_i : (e_if ? 4'hF : 4'h0);
    e_if_rdata = (resp && !m_owner_ls) ? mem_rdata_i : '0;
    e_ls_rdata = (resp && m_owner_ls && !m_owner_we) ? mem_rdata_i : '0;

    n_vec++;
    chk("if_gnt", if_gnt_o, e_if);
    chk("ls_gnt", ls_gnt_o, e_ls);
    chk("mem_en", mem_en_o, e_if || e_ls);
    chk("mem_we", mem_we_o, e_ls && ls_we_i);
    chk("mem_be", mem_be_o, e_be);
    chk("mem_addr", mem_addr_o, e_addr);
    chk("mem_wdata", mem_wdata_o, e_wdata);
    chk("if_rvalid", if_rvalid_o, resp && !m_owner_ls);
    chk("ls_rvalid", ls_rvalid_o, resp && m_owner_ls);
    chk("if_rdata", if_rdata_o, e_if_rdata);
    chk("ls_rdata", ls_rdata_o, e_ls_rdata);

    m_if_gnt = e_if;
    m_ls_gnt = e_ls;
    if (!rst_n) begin
      m_busy    = 1'b0;
      m_last_ls = 1'b0;
    end else if (e_if || e_ls) begin
      m_busy     = 1'b1;
      m_due      = m_cyc + LAT;
      m_owner_ls = e_ls;
      m_owner_we = e_ls && ls_we_i;
      m_last_ls  = e_ls;
    end else if (resp) begin
      m_busy = 1'b0;
    end
    m_cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  logic [3:0] be_tab [7] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};

  initial begin
    rst_n = 1'b0; if_req_i = 1'b1; if_addr_i = '0;
    ls_req_i = 1'b1; ls_we_i = 1'b0; ls_be_i = 4'hF; ls_addr_i = '0; ls_wdata_i = '0;
    mem_rdata_i = 32'h0000_0013;
    repeat (3) tick();
    at_neg();
    lit("rst_if_gnt", if_gnt_o, 0);
    lit("rst_ls_gnt", ls_gnt_o, 0);
    lit("rst_mem_en", mem_en_o, 0);
    lit("rst_mem_be", mem_be_o, 0);

    // Fetch of 0x100, data back two cycles later.
    tick(); rst_n = 1'b1; ls_req_i = 1'b0; if_addr_i = 32'h100;
    at_neg();
    lit("fetch_gnt", if_gnt_o, 1);
    lit("fetch_en", mem_en_o, 1);
    lit("fetch_addr", mem_addr_o, 32'h100);
    lit("fetch_be", mem_be_o, 4'hF);
    lit("fetch_we", mem_we_o, 0);
    tick(); if_req_i = 1'b0;
    at_neg();
    lit("fetch_early_rvalid", if_rvalid_o, 0);
    tick();
    at_neg();
    lit("fetch_rvalid", if_rvalid_o, 1);
    lit("fetch_rdata", if_rdata_o, 32'h0000_0013);
    lit("fetch_ls_rvalid", ls_rvalid_o, 0);

    // Tie: LS first, then the response-cycle grant depends on the mode.
    tick(); if_req_i = 1'b1; if_addr_i = 32'h80;
    ls_req_i = 1'b1; ls_we_i = 1'b0; ls_be_i = 4'hF; ls_addr_i = 32'h40;
    at_neg();
    lit("tie1_ls_gnt", ls_gnt_o, 1);
    lit("tie1_if_gnt", if_gnt_o, 0);
    lit("tie1_addr", mem_addr_o, 32'h40);
    tick();
    at_neg();
    lit("tie_busy_gnt", {ls_gnt_o, if_gnt_o}, 0);
    tick();
    at_neg();
    lit("tie_ls_rvalid", ls_rvalid_o, 1);
    lit("tie_ls_rdata", ls_rdata_o, 32'h0000_0013);
`ifdef ARB_ROUND_ROBIN_EN
    lit("tie2_if_gnt", if_gnt_o, 1);
    lit("tie2_ls_gnt", ls_gnt_o, 0);
    lit("tie2_addr", mem_addr_o, 32'h80);
`else
    lit("tie2_if_gnt", if_gnt_o, 0);
    lit("tie2_ls_gnt", ls_gnt_o, 1);
    lit("tie2_addr", mem_addr_o, 32'h40);
`endif
    tick(); if_req_i = 1'b0; ls_req_i = 1'b0;
    repeat (3) tick();

    // SB store to byte lane 2.
    ls_req_i = 1'b1; ls_we_i = 1'b1; ls_be_i = 4'h4;
    ls_addr_i = 32'h202; ls_wdata_i = 32'h00AB_0000;
    at_neg();
    lit("sb_gnt", ls_gnt_o, 1);
    lit("sb_we", mem_we_o, 1);
    lit("sb_be", mem_be_o, 4'h4);
    lit("sb_addr", mem_addr_o, 32'h202);
    lit("sb_wdata", mem_wdata_o, 32'h00AB_0000);
    tick(); ls_req_i = 1'b0; ls_we_i = 1'b0;
    tick();
    at_neg();
    lit("sb_rvalid", ls_rvalid_o, 1);
    lit("sb_rdata", ls_rdata_o, 0);

    // Reset during an outstanding load drops its response.
    tick(); ls_req_i = 1'b1; ls_be_i = 4'hF; ls_addr_i = 32'h300;
    at_neg();
    lit("rstmid_gnt", ls_gnt_o, 1);
    tick(); ls_req_i = 1'b0; rst_n = 1'b0;
    at_neg();
    lit("rstmid_en", mem_en_o, 0);
    lit("rstmid_ls_rvalid", ls_rvalid_o, 0);
    tick(); rst_n = 1'b1; if_req_i = 1'b1; if_addr_i = 32'h104;
    at_neg();
    lit("rstmid_no_rvalid", ls_rvalid_o, 0);
    lit("rstmid_fetch_gnt", if_gnt_o, 1);
    lit("rstmid_fetch_addr", mem_addr_o, 32'h104);
    tick(); if_req_i = 1'b0;

    // Randomized traffic: requests held until granted, occasionally withdrawn.
    for (int i = 0; i < 3000; i++) begin
      tick();
      rst_n = ($urandom_range(0, 199) != 0);
      mem_rdata_i = $urandom;
      if (if_req_i && !m_if_gnt) begin
        if ($urandom_range(0, 7) == 0) if_req_i = 1'b0;
      end else begin
        if_req_i  = ($urandom_range(0, 9) < 6);
        if_addr_i = $urandom;
      end
      if (ls_req_i && !m_ls_gnt) begin
        if ($urandom_range(0, 7) == 0) ls_req_i = 1'b0;
      end else begin
        ls_req_i   = ($urandom_range(0, 9) < 6);
        ls_we_i    = $urandom_range(0, 1) == 1;
        ls_be_i    = be_tab[$urandom_range(0, 6)];
        ls_addr_i  = $urandom;
        ls_wdata_i = $urandom;
      end
    end
    tick(); if_req_i = 1'b0; ls_req_i = 1'b0; rst_n = 1'b1;
    repeat (4) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
